// File: rtl/seq_detector_n.sv
// seq_detector_n: programmable DEPTH-step value/mask sequence monitor with one-hot state, match pulse and saturating count; SEQ_TIMEOUT_EN adds a stall timeout
module seq_detector_n #(
  parameter int IN_W   = 2,
  parameter int DEPTH  = 3,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8,
  parameter int TO_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [IN_W-1:0]       in_sig,
  input  logic [DEPTH*IN_W-1:0] pat_val,
  input  logic [DEPTH*IN_W-1:0] pat_mask,
  input  logic                  clr_cnt,
  output logic [DEPTH-1:0]      state,
  output logic                  busy,
  output logic                  match,
  output logic [CNT_W-1:0]      match_cnt,
  output logic                  timeout
);
  logic [DEPTH-1:0] cond, step_d, state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             legal, hit, expire, match_d, match_q, timeout_d, timeout_q;
  if (DEPTH < 2 || TO_CYC < 1) begin : g_bad_param
    $error("seq_detector_n: DEPTH must be >= 2 and TO_CYC >= 1");
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_cond
    assign cond[k] = ((in_sig ^ pat_val[k*IN_W +: IN_W]) & pat_mask[k*IN_W +: IN_W]) == '0;
  end
  always_comb begin
    legal     = state_q != '0 && (state_q & (state_q - 1'b1)) == '0;
    hit       = |(state_q & cond);
    step_d    = hit ? (state_q[DEPTH-1] ? DEPTH'(1) : state_q << 1)
              : (MODE == 0) ? ((!state_q[0] && cond[0]) ? DEPTH'(2) : DEPTH'(1))
              : state_q;
    state_d   = (!legal || expire) ? DEPTH'(1) : en ? step_d : state_q;
    match_d   = legal && en && hit && state_q[DEPTH-1];
    timeout_d = expire;
    cnt_d     = clr_cnt ? '0 : (match_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
`ifdef SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_d, to_q;
  logic            stall;
  // a step-1 restart leaves state unchanged, so it counts as a stall too
  always_comb begin
    stall  = legal && en && !state_q[0] && step_d == state_q;
    expire = stall && to_q == TO_W'(TO_CYC - 1);
    to_d   = (stall && !expire) ? to_q + 1'b1 : (legal && !en) ? to_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) to_q <= '0;
    else to_q <= to_d;
  end
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DEPTH'(1);
      match_q   <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign state     = state_q;
  assign busy      = ~state_q[0];
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign timeout   = timeout_q;
endmodule
